// File: rtl/aemb_intc.sv
// -----------------------------------------------------------------------------
// aemb_intc
// Wishbone-slave interrupt controller feeding the core's sys_int_i input.
// Collects NSRC external sources (edge or level triggered per EDGE), latches
// them in ISR, masks them with IER and the MER master enable, and drives one
// registered interrupt level that holds until software services it.
//
// Ports
//   sys_clk_i  in   1     clock, rising edge
//   sys_rst_i  in   1     asynchronous active-high reset
//   irq_i      in   NSRC  raw interrupt sources (asynchronous)
//   dwb_stb_i  in   1     Wishbone strobe, held until ack
//   dwb_we_i   in   1     1 = write, 0 = read
//   dwb_adr_i  in   3     word register index
//   dwb_dat_i  in   32    write data
//   dwb_dat_o  out  32    registered read data
//   dwb_ack_o  out  1     transfer acknowledge
//   sys_int_o  out  1     interrupt request to the core
//
// Register map: 0 ISR (W1C), 1 IPR (RO), 2 IER (RW), 3 IVR (RO),
//               4 MER (RW, bit 0), 5..7 read 0.
// -----------------------------------------------------------------------------
module aemb_intc #(
  parameter int          NSRC = 8,
  parameter logic [31:0] EDGE = 32'hFFFF_FFFF
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [NSRC-1:0] irq_i,
  input  logic            dwb_stb_i,
  input  logic            dwb_we_i,
  input  logic [2:0]      dwb_adr_i,
  input  logic [31:0]     dwb_dat_i,
  output logic [31:0]     dwb_dat_o,
  output logic            dwb_ack_o,
  output logic            sys_int_o
);

  localparam logic [NSRC-1:0] LP_EDGE = EDGE[NSRC-1:0];

  localparam logic [2:0] ADR_ISR = 3'd0;
  localparam logic [2:0] ADR_IPR = 3'd1;
  localparam logic [2:0] ADR_IER = 3'd2;
  localparam logic [2:0] ADR_IVR = 3'd3;
  localparam logic [2:0] ADR_MER = 3'd4;

  logic [NSRC-1:0] r_s1, r_s2, r_s3;
  logic [NSRC-1:0] r_isr, r_ier;
  logic            r_mer;
  logic            r_ack;
  logic            r_int;
  logic [31:0]     r_dat;

  logic            w_fire, w_wr, w_rd;
  logic [NSRC-1:0] w_clr, w_rise, w_ipr;
  logic [31:0]     w_ivr, w_rdat;
  logic            w_unused;

  // Only the first cycle of a strobe executes; while the strobe is held the
  // registered ack blocks any repeat of the same access.
  assign w_fire = dwb_stb_i & ~r_ack;
  assign w_wr   = w_fire & dwb_we_i;
  assign w_rd   = w_fire & ~dwb_we_i;

  assign w_clr  = (w_wr && dwb_adr_i == ADR_ISR) ? dwb_dat_i[NSRC-1:0] : '0;
  assign w_rise = r_s2 & ~r_s3;
  assign w_ipr  = r_isr & r_ier;

  // Write-data bits above NSRC (and above bit 0 for MER) carry no state.
  assign w_unused = ^dwb_dat_i;

  // Synchroniser plus one history flop for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= irq_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Edge bits: clear-then-set so a new edge wins over a simultaneous W1C.
  // Level bits: follow the synchronised input and ignore writes.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_isr <= '0;
    end else begin
      r_isr <= (LP_EDGE & ((r_isr & ~w_clr) | w_rise)) | (~LP_EDGE & r_s2);
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_ier <= '0;
      r_mer <= 1'b0;
    end else if (w_wr) begin
      if (dwb_adr_i == ADR_IER) r_ier <= dwb_dat_i[NSRC-1:0];
      if (dwb_adr_i == ADR_MER) r_mer <= dwb_dat_i[0];
    end
  end

  // Lowest-numbered pending source has highest priority; scanning downward
  // lets the lowest index overwrite any higher one.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ivr = 32'hFFFF_FFFF;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_ipr[i]) w_ivr = 32'(i);
    end
  end

  always_comb begin
    w_rdat = '0;
    case (dwb_adr_i)
      ADR_ISR: w_rdat = 32'(r_isr);
      ADR_IPR: w_rdat = 32'(w_ipr);
      ADR_IER: w_rdat = 32'(r_ier);
      ADR_IVR: w_rdat = w_ivr;
      ADR_MER: w_rdat = {31'd0, r_mer};
      default: w_rdat = '0;
    endcase
  end

  // Bus outputs and the interrupt line. Reset drops ack at once, so a
  // transfer interrupted by reset never completes.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_int <= 1'b0;
    end else begin
      r_ack <= dwb_stb_i;
      if (w_rd) r_dat <= w_rdat;
      r_int <= r_mer & (|w_ipr);
    end
  end

  assign dwb_ack_o = r_ack;
  assign dwb_dat_o = r_dat;
  assign sys_int_o = r_int;

endmodule

// File: tb/tb_aemb_intc.sv
// -----------------------------------------------------------------------------
// tb_aemb_intc
// Directed bench for aemb_intc with NSRC=8 and source 0 level triggered
// (EDGE=...FE), all other sources rising-edge. A table of bus accesses covers
// the register map; hand-written sequences cover interrupt latency, level
// behaviour, priority/masking, the clear/set race and the held-strobe handshake.
// -----------------------------------------------------------------------------
module tb_aemb_intc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [2:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        sint;

  int n_vec = 0;
  int n_err = 0;

  aemb_intc #(.NSRC(8), .EDGE(32'hFFFF_FFFE)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .irq_i     (irq),
    .dwb_stb_i (stb),
    .dwb_we_i  (we),
    .dwb_adr_i (adr),
    .dwb_dat_i (wdat),
    .dwb_dat_o (rdat),
    .dwb_ack_o (ack),
    .sys_int_o (sint)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    d = rdat;
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    @(negedge clk);
    irq = irq | m;
    @(negedge clk);
    irq = irq & ~m;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] d;

    vecs.push_back('{1'b0, 3'd0, 32'h0000_0000, "rst_isr"});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_0000, "rst_ipr"});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0000, "rst_ier"});
    vecs.push_back('{1'b0, 3'd3, 32'hFFFF_FFFF, "rst_ivr"});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_0000, "rst_mer"});
    vecs.push_back('{1'b0, 3'd5, 32'h0000_0000, "rd5"});
    vecs.push_back('{1'b0, 3'd7, 32'h0000_0000, "rd7"});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FF05, "wr_ier"});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0005, "ier_masked"});
    vecs.push_back('{1'b1, 3'd4, 32'hFFFF_FFFF, "wr_mer"});
    vecs.push_back('{1'b0, 3'd4, 32'h0000_0001, "mer_bit0"});
    vecs.push_back('{1'b1, 3'd6, 32'hDEAD_BEEF, "wr6"});
    vecs.push_back('{1'b0, 3'd6, 32'h0000_0000, "rd6"});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_00FF, "wr_ipr"});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_0000, "ipr_ro"});

    // Reset asserted mid-read: outputs clear immediately.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 3'd3;
    @(posedge clk); #1;
    check("pre_rst_ack", {31'd0, ack}, 32'd1);
    check("pre_rst_dat", rdat, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_int", {31'd0, sint}, 32'd0);
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register-map table.
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].adr, vecs[i].data);
      end else begin
        wb_read(vecs[i].adr, d);
        check(vecs[i].name, d, vecs[i].data);
      end
    end

    // Edge path: IER=05, ME=1 from the table. One-cycle pulse on source 2.
    pulse_irq(8'h04);                    // consumes edge 1
    repeat (2) @(posedge clk); #1;       // edge 3
    check("edge_lat3", {31'd0, sint}, 32'd0);
    @(posedge clk); #1;                  // edge 4
    check("edge_lat4", {31'd0, sint}, 32'd1);
    wb_read(3'd3, d); check("edge_ivr", d, 32'd2);
    wb_read(3'd0, d); check("edge_isr", d, 32'h04);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 3'd0; wdat = 32'h04;
    @(posedge clk); #1;
    check("w1c_ack", {31'd0, ack}, 32'd1);
    check("w1c_int_hold", {31'd0, sint}, 32'd1);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("w1c_int_fall", {31'd0, sint}, 32'd0);

    // Level path on source 0.
    @(negedge clk);
    irq[0] = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("lvl_int", {31'd0, sint}, 32'd1);
    wb_write(3'd0, 32'h01);
    @(posedge clk); #1;
    check("lvl_w1c_int", {31'd0, sint}, 32'd1);
    wb_read(3'd0, d); check("lvl_isr", d, 32'h01);
    @(negedge clk);
    irq[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("lvl_fall3", {31'd0, sint}, 32'd1);
    @(posedge clk); #1;
    check("lvl_fall4", {31'd0, sint}, 32'd0);

    // Priority and masking.
    wb_write(3'd2, 32'hFF);
    pulse_irq(8'h48);
    repeat (4) @(posedge clk); #1;
    wb_read(3'd0, d); check("pri_isr", d, 32'h48);
    wb_read(3'd3, d); check("pri_ivr3", d, 32'd3);
    wb_write(3'd2, 32'h40);
    wb_read(3'd3, d); check("pri_ivr6", d, 32'd6);
    check("pri_int_on", {31'd0, sint}, 32'd1);
    wb_write(3'd4, 32'h0);
    check("me_off_int", {31'd0, sint}, 32'd0);
    wb_read(3'd1, d); check("me_off_ipr", d, 32'h40);
    wb_write(3'd4, 32'h1);
    wb_write(3'd0, 32'hFF);
    wb_read(3'd0, d); check("pri_cleared", d, 32'h00);

    // Race: set ISR[1], then re-trigger in the same cycle as its W1C.
    wb_write(3'd2, 32'hFF);
    pulse_irq(8'h02);
    repeat (4) @(posedge clk); #1;
    wb_read(3'd0, d); check("race_pre", d, 32'h02);
    @(negedge clk);
    irq[1] = 1'b1;
    repeat (2) @(posedge clk);           // s2 rises, s3 still low
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 3'd0; wdat = 32'h02;
    @(posedge clk); #1;                  // edge set and W1C coincide
    @(negedge clk);
    stb = 1'b0; we = 1'b0; irq[1] = 1'b0;
    @(posedge clk); #1;
    wb_read(3'd0, d); check("race_set_wins", d, 32'h02);
    wb_write(3'd0, 32'h02);
    wb_read(3'd0, d); check("race_plain_clr", d, 32'h00);

    // Edge on source 5 arriving as a write to IER fires.
    @(negedge clk);
    irq[5] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 3'd2; wdat = 32'hFF;
    @(posedge clk); #1;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; irq[5] = 1'b0;
    @(posedge clk); #1;
    wb_read(3'd0, d); check("fire_keep_edge", d, 32'h20);
    wb_write(3'd0, 32'h20);

    // Held strobe: one write only, ack tracks stb, dat_o untouched by writes.
    wb_read(3'd2, d); check("hs_ier_before", d, 32'hFF);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 3'd2; wdat = 32'h0F;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hs_ack_c%0d", c), {31'd0, ack}, 32'd1);
      @(negedge clk);
      wdat = 32'hF0;                     // a re-executed write would land this
    end
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("hs_ack_fall", {31'd0, ack}, 32'd0);
    check("hs_dat_hold", rdat, 32'hFF);
    wb_read(3'd2, d); check("hs_single_wr", d, 32'h0F);
    wb_read(3'd6, d); check("hs_rd6", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
